// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem request channel, one-entry skid buffer and IF/ID register.
// Responses belonging to fetches squashed by an execute redirect are drained and dropped.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall_d,
  input  logic        redirect_e,
  input  logic [31:0] redirect_pc_e,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);
  typedef enum logic [1:0] {BOOT, ISSUE, WAIT, DRAIN} state_t;
  state_t state, state_n;
  logic [31:0] pc_f, pc_f_n, req_pc, buf_instr, buf_pc, ld_instr, ld_pc;
  logic buf_full, hs, deliver, ld;
  assign imem_req_valid = state == ISSUE && !buf_full;
  assign imem_req_addr = pc_f;
  assign hs = imem_req_valid && imem_req_ready;
  assign deliver = state == WAIT && imem_rsp_valid && !redirect_e;
  assign ld = buf_full || deliver;
  assign ld_instr = buf_full ? buf_instr : imem_rsp_data;
  assign ld_pc = buf_full ? buf_pc : req_pc;
  always_comb begin
    state_n = state;
    pc_f_n = redirect_e && state != BOOT ? redirect_pc_e : hs ? pc_f + 32'd4 : pc_f;
    case (state)
      BOOT:    state_n = ISSUE;
      ISSUE:   state_n = hs ? (redirect_e ? DRAIN : WAIT) : ISSUE;
      WAIT:    state_n = imem_rsp_valid ? ISSUE : redirect_e ? DRAIN : WAIT;
      DRAIN:   state_n = imem_rsp_valid ? ISSUE : DRAIN;
      default: state_n = BOOT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= BOOT;
      pc_f <= RESET_PC;
    end else begin
      state <= state_n;
      pc_f <= pc_f_n;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      req_pc <= '0;
      buf_full <= 1'b0;
      buf_instr <= '0;
      buf_pc <= '0;
      valid_d <= 1'b0;
      instr_d <= '0;
      pc_d <= '0;
      pc_plus4_d <= '0;
    end else begin
      if (hs) req_pc <= pc_f;
      // a stalled delivery parks in the buffer; issue is blocked until it drains
      if (deliver && stall_d) begin
        buf_full <= 1'b1;
        buf_instr <= imem_rsp_data;
        buf_pc <= req_pc;
      end
      if (redirect_e) begin
        valid_d <= 1'b0;
        buf_full <= 1'b0;
      end else if (!stall_d) begin
        valid_d <= ld;
        if (buf_full) buf_full <= 1'b0;
        if (ld) begin
          instr_d <= ld_instr;
          pc_d <= ld_pc;
          pc_plus4_d <= ld_pc + 32'd4;
        end
      end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed fetch-stage bench with a one-cycle-latency memory and an IF/ID scoreboard.
module tb_fetch_stage;
  typedef struct packed {logic [31:0] instr, pc;} exp_t;
  logic clk = 1'b0, rst_n, imem_req_valid, imem_req_ready, imem_rsp_valid, stall_d, redirect_e, valid_d;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc_e, instr_d, pc_d, pc_plus4_d;
  exp_t q[$];
  int checks = 0, errors = 0, hs_cnt = 0, hs0;
  logic auto_rsp, live, pend;
  logic [31:0] exp_pc, cur_req, pend_addr, x, y, a;
  fetch_stage #(.RESET_PC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall_d(stall_d), .redirect_e(redirect_e), .redirect_pc_e(redirect_pc_e), .instr_d(instr_d),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic got, input logic exp);
    chk(tag, {31'd0, got}, {31'd0, exp});
  endtask
  // Sample at the falling edge, model memory/decode, then drive the next cycle after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (valid_d && (!stall_d || redirect_e)) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL sb_extra: got instr %h pc %h expected no instruction", instr_d, pc_d);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_instr", instr_d, e.instr);
        chk("sb_pc", pc_d, e.pc);
        chk("sb_pc_plus4", pc_plus4_d, e.pc + 32'd4);
      end
    end
    if (redirect_e) q.delete();
    if (imem_rsp_valid && live && !redirect_e) q.push_back('{instr: imem_rsp_data, pc: cur_req});
    if (imem_rsp_valid) live = 1'b0;
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_pc);
      hs_cnt++;
      cur_req = imem_req_addr;
      live = !redirect_e;
      pend = 1'b1;
      pend_addr = imem_req_addr;
      if (!redirect_e) exp_pc = exp_pc + 32'd4;
    end
    if (redirect_e) begin
      exp_pc = redirect_pc_e;
      live = 1'b0;
    end
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      imem_rsp_valid = pend;
      imem_rsp_data = pend_addr;
    end
    pend = 1'b0;
  endtask
  task automatic wait_req();
    int n = 0;
    while (!imem_req_valid && n < 20) begin
      tick();
      n++;
    end
    chk1("req_wait", imem_req_valid, 1'b1);
  endtask
  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    stall_d = 1'b0; redirect_e = 1'b0; redirect_pc_e = '0;
    auto_rsp = 1'b1; live = 1'b0; pend = 1'b0; pend_addr = '0; cur_req = '0; exp_pc = 32'h100;
    repeat (2) tick();
    chk1("rst_valid_d", valid_d, 1'b0);
    chk("rst_instr_d", instr_d, 32'h0);
    chk("rst_pc_d", pc_d, 32'h0);
    chk("rst_pc_plus4_d", pc_plus4_d, 32'h0);
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    rst_n = 1'b1;
    chk1("boot_no_req", imem_req_valid, 1'b0);
    tick();
    chk1("first_req_valid", imem_req_valid, 1'b1);
    chk("first_req_addr", imem_req_addr, 32'h100);
    repeat (6) tick();
    chk("seq_pc_d", pc_d, 32'h108);
    chk("seq_pc_plus4", pc_plus4_d, 32'h10C);
    // request backpressure
    wait_req();
    imem_req_ready = 1'b0;
    a = imem_req_addr;
    repeat (3) begin
      tick();
      chk1("bp_valid", imem_req_valid, 1'b1);
      chk("bp_addr_stable", imem_req_addr, a);
    end
    imem_req_ready = 1'b1;
    hs0 = hs_cnt;
    tick();
    chk("bp_one_accept", hs_cnt, hs0 + 1);
    chk1("bp_wait_no_req", imem_req_valid, 1'b0);
    // decode stall with the response parked in the buffer
    wait_req();
    chk1("stall_pre_valid", valid_d, 1'b1);
    x = pc_d;
    y = imem_req_addr;
    stall_d = 1'b1;
    repeat (4) begin
      tick();
      chk("stall_hold_pc", pc_d, x);
      chk1("stall_hold_valid", valid_d, 1'b1);
      chk1("stall_no_req", imem_req_valid, 1'b0);
    end
    stall_d = 1'b0;
    tick();
    chk("unstall_pc", pc_d, y);
    chk1("unstall_valid", valid_d, 1'b1);
    chk1("unstall_req", imem_req_valid, 1'b1);
    // redirect with a request outstanding, stale response two cycles later
    wait_req();
    auto_rsp = 1'b0;
    tick();
    redirect_e = 1'b1; redirect_pc_e = 32'h200;
    tick();
    redirect_e = 1'b0;
    chk1("redir_bubble", valid_d, 1'b0);
    chk1("redir_drain_no_req", imem_req_valid, 1'b0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD;
    tick();
    imem_rsp_valid = 1'b0;
    auto_rsp = 1'b1;
    chk1("redir_req_valid", imem_req_valid, 1'b1);
    chk("redir_req_addr", imem_req_addr, 32'h200);
    repeat (4) tick();
    // redirect while stalled with a full buffer
    wait_req();
    stall_d = 1'b1;
    repeat (2) tick();
    redirect_e = 1'b1; redirect_pc_e = 32'h300;
    tick();
    redirect_e = 1'b0; stall_d = 1'b0;
    chk1("stall_redir_bubble", valid_d, 1'b0);
    chk1("stall_redir_req", imem_req_valid, 1'b1);
    chk("stall_redir_addr", imem_req_addr, 32'h300);
    repeat (4) tick();
    // response and redirect in the same cycle
    wait_req();
    auto_rsp = 1'b0;
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBEEF;
    redirect_e = 1'b1; redirect_pc_e = 32'h400;
    tick();
    imem_rsp_valid = 1'b0; redirect_e = 1'b0;
    auto_rsp = 1'b1;
    chk1("same_redir_bubble", valid_d, 1'b0);
    chk1("same_redir_req", imem_req_valid, 1'b1);
    chk("same_redir_addr", imem_req_addr, 32'h400);
    repeat (4) tick();
    // wrap-around at the top of the address space
    wait_req();
    imem_req_ready = 1'b0;
    redirect_e = 1'b1; redirect_pc_e = 32'hFFFF_FFFC;
    tick();
    redirect_e = 1'b0; imem_req_ready = 1'b1;
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    repeat (2) tick();
    chk1("wrap_valid", valid_d, 1'b1);
    chk("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4_d, 32'h0);
    chk("wrap_next_addr", imem_req_addr, 32'h0);
    tick();
    // asynchronous reset in the middle of WAIT
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_valid_d", valid_d, 1'b0);
    chk1("mid_rst_req_valid", imem_req_valid, 1'b0);
    chk("mid_rst_pc_d", pc_d, 32'h0);
    q.delete();
    exp_pc = 32'h100; live = 1'b0; pend = 1'b0; auto_rsp = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD;
    tick();
    rst_n = 1'b1;
    tick();
    imem_rsp_valid = 1'b0;
    auto_rsp = 1'b1;
    chk1("restart_req_valid", imem_req_valid, 1'b1);
    chk("restart_req_addr", imem_req_addr, 32'h100);
    repeat (7) tick();
    chk("sb_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
